binary_to_unary_ramp: RTL and testbench

BINARY_TO_UNARY_RAMP -- requirements
Module: binary_to_unary_ramp

---
 rtl/binary_to_unary_ramp.sv | 139 +++++++++++++
 tb/tb_binary_to_unary_ramp.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/binary_to_unary_ramp.sv
// binary_to_unary_ramp: walks a registered thermometer code toward a
// requested level, one level every STEP_CYCLES clocks, then pulses done_o.
//
// Optional feature: define BIN2UNARY_ABORT_EN to add abort_i, which freezes
// the current level and ends an active ramp.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   target_valid_i   a new target level is offered
//   target_ready_o   block is idle and accepts a target this cycle
//   target_i         requested level 0..UNARY_SIZE (larger values saturate)
//   abort_i          (BIN2UNARY_ABORT_EN only) stop an active ramp in place
//   unary_o          thermometer code, unary_o[k] = (k < level_o)
//   level_o          current level in binary
//   busy_o           a ramp is in progress
//   done_o           one-cycle pulse when the target is reached or aborted
module binary_to_unary_ramp #(
  parameter  int unsigned UNARY_SIZE  = 16,
  parameter  int unsigned STEP_CYCLES = 4,
  localparam int unsigned LEVEL_W     = $clog2(UNARY_SIZE + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               target_valid_i,
  output logic               target_ready_o,
  input  logic [LEVEL_W-1:0] target_i,
`ifdef BIN2UNARY_ABORT_EN
  input  logic               abort_i,
`endif
  output logic               unary_o [UNARY_SIZE],
  output logic [LEVEL_W-1:0] level_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned          TIMER_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TIMER_W-1:0]   TIMER_RELOAD = TIMER_W'(STEP_CYCLES - 1);
  localparam logic [LEVEL_W-1:0]   LEVEL_MAX    = LEVEL_W'(UNARY_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q;
  state_e               state_d;
  logic [LEVEL_W-1:0]   level_d;
  logic [LEVEL_W-1:0]   target_q;
  logic [LEVEL_W-1:0]   target_d;
  logic [TIMER_W-1:0]   timer_q;
  logic [TIMER_W-1:0]   timer_d;
  logic [LEVEL_W-1:0]   target_sat_c;
  logic                 handshake_c;
  logic                 abort_c;

  // Ready is a decode of the state flop, held low while reset is applied so
  // the first edge after release can already take a target.
  assign target_ready_o = (state_q == IDLE) && !rst_i;

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    level_d      = level_o;
    target_d     = target_q;
    timer_d      = timer_q;
    target_sat_c = (target_i > LEVEL_MAX) ? LEVEL_MAX : target_i;
    handshake_c  = target_valid_i && target_ready_o;
`ifdef BIN2UNARY_ABORT_EN
    abort_c      = abort_i;
`else
    abort_c      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (handshake_c) begin
          target_d = target_sat_c;
          if (target_sat_c == level_o) begin
            state_d = DONE;
          end else begin
            state_d = RAMP;
            timer_d = TIMER_RELOAD;
          end
        end
      end

      RAMP: begin
        if (abort_c) begin
          // Level stays where it is; the ramp simply ends.
          state_d = DONE;
        end else if (timer_q == '0) begin
          level_d = (target_q > level_o) ? level_o + LEVEL_W'(1)
                                         : level_o - LEVEL_W'(1);
          timer_d = TIMER_RELOAD;
          if (level_d == target_q) begin
            state_d = DONE;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, level, thermometer and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      level_o  <= '0;
      target_q <= '0;
      timer_q  <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      for (int unsigned k = 0; k < UNARY_SIZE; k++) begin
        unary_o[k] <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      level_o  <= level_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      busy_o   <= (state_d == RAMP);
      done_o   <= (state_d == DONE);
      for (int unsigned k = 0; k < UNARY_SIZE; k++) begin
        unary_o[k] <= (LEVEL_W'(k) < level_d);
      end
    end
  end

endmodule

// File: tb/tb_binary_to_unary_ramp.sv
// Directed bench for binary_to_unary_ramp at default parameters
// (UNARY_SIZE=16, STEP_CYCLES=4). Abort scenario runs only when
// BIN2UNARY_ABORT_EN is defined.
module tb_binary_to_unary_ramp;

  localparam int unsigned USZ  = 16;
  localparam int          STEP = 4;
  localparam int unsigned LW   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          target_valid;
  logic          target_ready;
  logic [LW-1:0] target;
  logic          unary [USZ];
  logic [LW-1:0] level;
  logic          busy;
  logic          done;
`ifdef BIN2UNARY_ABORT_EN
  logic          abort;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  binary_to_unary_ramp #(
    .UNARY_SIZE  (USZ),
    .STEP_CYCLES (STEP)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .target_valid_i (target_valid),
    .target_ready_o (target_ready),
    .target_i       (target),
`ifdef BIN2UNARY_ABORT_EN
    .abort_i        (abort),
`endif
    .unary_o        (unary),
    .level_o        (level),
    .busy_o         (busy),
    .done_o         (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pack_u();
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = unary[k];
    return r;
  endfunction

  function automatic logic [15:0] therm(input int n);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = (k < n);
    return r;
  endfunction

  // Offer tgt at the next edge, then follow the whole ramp from start to fin
  // cycle by cycle until the block is back in IDLE.
  task automatic ramp(input string tag, input logic [LW-1:0] tgt, input int start,
                      input int fin, input bit hold_zero, input logic [15:0] final_u);
    int d;
    int dir;
    int lvl;
    int cc;
    d   = (fin > start) ? fin - start : start - fin;
    dir = (fin >= start) ? 1 : -1;
    check({tag, " ready_before"}, 32'(target_ready), 32'd1);
    target_valid = 1'b1;
    target       = tgt;
    @(posedge clk); #1;
    if (hold_zero) target = '0;
    else           target_valid = 1'b0;
    for (int c = 0; c <= d * STEP + 1; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      cc  = (c > d * STEP) ? d * STEP : c;
      lvl = start + dir * (cc / STEP);
      check($sformatf("%s c%0d level", tag, c), 32'(level), 32'(lvl));
      check($sformatf("%s c%0d unary", tag, c), 32'(pack_u()), 32'(therm(lvl)));
      check($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(c < d * STEP));
      check($sformatf("%s c%0d done", tag, c), 32'(done), 32'(c == d * STEP));
      check($sformatf("%s c%0d ready", tag, c), 32'(target_ready), 32'(c == d * STEP + 1));
    end
    check({tag, " final_unary"}, 32'(pack_u()), 32'(final_u));
  endtask

  initial begin
    rst          = 1'b1;
    target_valid = 1'b0;
    target       = '0;
`ifdef BIN2UNARY_ABORT_EN
    abort        = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst level", 32'(level), 32'd0);
    check("rst unary", 32'(pack_u()), 32'h0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst ready", 32'(target_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst ready", 32'(target_ready), 32'd1);

    // Ramp up, ramp down, saturation, walk back to 7
    ramp("up5",   5'd5,  0,  5,  1'b0, 16'h001F);
    ramp("down2", 5'd2,  5,  2,  1'b0, 16'h0003);
    ramp("sat31", 5'd31, 2,  16, 1'b0, 16'hFFFF);
    ramp("to7",   5'd7,  16, 7,  1'b0, 16'h007F);
    // Target equal to current level: immediate done, no busy
    ramp("same7", 5'd7,  7,  7,  1'b0, 16'h007F);
    // valid held high with target 0 during the ramp; 0 accepted only after
    ramp("hold9", 5'd9,  7,  9,  1'b1, 16'h01FF);
    ramp("down0", 5'd0,  9,  0,  1'b0, 16'h0000);

    // Reset in the middle of a ramp to 10, at level 3
    target_valid = 1'b1;
    target       = 5'd10;
    @(posedge clk); #1;
    target_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("mid level3", 32'(level), 32'd3);
    check("mid busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst level", 32'(level), 32'd0);
    check("mid_rst unary", 32'(pack_u()), 32'h0);
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst ready", 32'(target_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("mid_rst done%0d", i), 32'(done), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("mid_rst_rel ready", 32'(target_ready), 32'd1);
    ramp("after_rst1", 5'd1, 0, 1, 1'b0, 16'h0001);

`ifdef BIN2UNARY_ABORT_EN
    // Abort at level 6 of a ramp 1 -> 12
    target_valid = 1'b1;
    target       = 5'd12;
    @(posedge clk); #1;
    target_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort pre level6", 32'(level), 32'd6);
    check("abort pre busy", 32'(busy), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort level", 32'(level), 32'd6);
    check("abort unary", 32'(pack_u()), 32'h003F);
    check("abort done", 32'(done), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("abort idle done", 32'(done), 32'd0);
    check("abort idle ready", 32'(target_ready), 32'd1);
    check("abort idle level", 32'(level), 32'd6);
    @(posedge clk); #1;
    check("abort ignored done", 32'(done), 32'd0);
    check("abort ignored ready", 32'(target_ready), 32'd1);
    abort = 1'b0;
    ramp("abort_resume", 5'd8, 6, 8, 1'b0, 16'h00FF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
